// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver. Turns the asynchronous serial line into a byte plus a
// one-cycle strobe for the downstream keypad/lock logic. The receiver
// synchronises the line, rejects short start-bit glitches, samples each bit
// in its middle and checks the stop bit for framing errors.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (legal values >= 4)
//   HALF_BIT      cycles from the start-bit falling edge to the start-bit
//                 mid-sample
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   raw serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last correctly received byte, held until the next
//                   good frame
//   rx_done    out  one-cycle pulse; rx_data is valid in the same cycle
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Terminal counts: the counter starts at 0 on every state entry and
    // every sample, so a span of N cycles ends when the counter reads N-1.
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift;
    logic [7:0]    shift_d;
    logic [7:0]    rx_data_d;
    logic          rx_done_d;
    logic          frame_err_d;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchroniser. Both flops reset to the idle (high) level so
    // that leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register together with the datapath registers. rx_done and
    // frame_err are registered so that they line up with the rx_data update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shift     <= shift_d;
            rx_data   <= rx_data_d;
            rx_done   <= rx_done_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state and datapath logic. The counter free-runs within a state
    // and is cleared whenever a sample is taken or a new state is entered.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + 1'b1;
        bit_idx_d   = bit_idx;
        shift_d     = shift;
        rx_data_d   = rx_data;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end

            STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit of
                // margin to catch a start bit that follows immediately.
                if (cnt == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d = shift;
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // A stuck-low line or break must go high before a new frame
                // can start, otherwise it would be read as endless 0x00 bytes.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Self-checking bench for uart_rx_byte. Two instances share clock and reset:
// one with CLKS_PER_BIT=16 for the main sequence and one with CLKS_PER_BIT=5
// (odd, HALF_BIT=2). Frames expected to complete are pushed onto a per-DUT
// queue when they are driven; monitors pop and compare on every rx_done.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int C16 = 16;
    localparam int C5  = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx16  = 1'b1;
    logic       rx5   = 1'b1;
    logic [7:0] rx_data16;
    logic       rx_done16;
    logic       frame_err16;
    logic       busy16;
    logic [7:0] rx_data5;
    logic       rx_done5;
    logic       frame_err5;
    logic       busy5;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp16[$];
    logic [7:0] exp5[$];
    int         done_times[$];
    int         done16_cnt  = 0;
    int         err16_cnt   = 0;
    int         done5_cnt   = 0;
    int         err5_cnt    = 0;
    int         pulse_viol  = 0;
    int         cycle       = 0;
    logic       prev_done16 = 1'b0;
    logic       prev_err16  = 1'b0;
    logic       prev_done5  = 1'b0;
    logic       prev_err5   = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    uart_rx_byte #(.CLKS_PER_BIT(C16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx16),
        .rx_data   (rx_data16),
        .rx_done   (rx_done16),
        .frame_err (frame_err16),
        .busy      (busy16)
    );

    uart_rx_byte #(.CLKS_PER_BIT(C5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx5),
        .rx_data   (rx_data5),
        .rx_done   (rx_done5),
        .frame_err (frame_err5),
        .busy      (busy5)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed,
                              input int lo, input int hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic driveLine(input bit sel, input logic v, input int n);
        if (sel) rx5 = v;
        else     rx16 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data,
                                 input logic stop_bit);
        int cpb;
        cpb = sel ? C5 : C16;
        if (stop_bit) begin
            if (sel) exp5.push_back(data);
            else     exp16.push_back(data);
        end
        driveLine(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) driveLine(sel, data[i], cpb);
        driveLine(sel, stop_bit, cpb);
    endtask

    task automatic waitDrain(input bit sel);
        int left;
        for (int i = 0; i < 2000; i++) begin
            left = sel ? exp5.size() : exp16.size();
            if (left == 0) break;
            @(negedge clk);
        end
        #1;
        left = sel ? exp5.size() : exp16.size();
        checkOutput(sel ? "drain5" : "drain16", left, 0);
    endtask

    // Scoreboard monitors: compare every rx_done against the queue head and
    // flag overlapping or stretched pulses.
    always @(negedge clk) begin
        if (rx_done16) begin
            done16_cnt++;
            done_times.push_back(cycle);
            if (exp16.size() == 0) checkOutput("spurious_done16", exp16.size(), 1);
            else checkOutput("rx_data16", rx_data16, exp16.pop_front());
        end
        if (frame_err16) err16_cnt++;
        if ((rx_done16 && frame_err16) || (rx_done16 && prev_done16) ||
            (frame_err16 && prev_err16)) pulse_viol++;
        prev_done16 = rx_done16;
        prev_err16  = frame_err16;
    end

    always @(negedge clk) begin
        if (rx_done5) begin
            done5_cnt++;
            if (exp5.size() == 0) checkOutput("spurious_done5", exp5.size(), 1);
            else checkOutput("rx_data5", rx_data5, exp5.pop_front());
        end
        if (frame_err5) err5_cnt++;
        if ((rx_done5 && frame_err5) || (rx_done5 && prev_done5) ||
            (frame_err5 && prev_err5)) pulse_viol++;
        prev_done5 = rx_done5;
        prev_err5  = frame_err5;
    end

    initial begin
        int         d;
        int         e;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", rx_data16, 8'h00);
        checkOutput("reset_rx_done", rx_done16, 1'b0);
        checkOutput("reset_frame_err", frame_err16, 1'b0);
        checkOutput("reset_busy", busy16, 1'b0);
        checkOutput("reset_busy5", busy5, 1'b0);
        reset = 1'b0;
        driveLine(0, 1'b1, 20);

        // Single frame 0x31
        $display("[TB] single frame 0x31");
        applyStimulus(0, 8'h31, 1'b1);
        waitDrain(0);
        checkOutput("single_done_count", done16_cnt, 1);
        checkOutput("single_busy_after", busy16, 1'b0);
        checkOutput("single_no_err", err16_cnt, 0);

        // Back-to-back "1416"
        $display("[TB] back-to-back 1416");
        done_times.delete();
        applyStimulus(0, 8'h31, 1'b1);
        applyStimulus(0, 8'h34, 1'b1);
        applyStimulus(0, 8'h31, 1'b1);
        applyStimulus(0, 8'h36, 1'b1);
        waitDrain(0);
        checkOutput("b2b_pulse_count", done_times.size(), 4);
        if (done_times.size() == 4) begin
            for (int i = 1; i < 4; i++)
                checkRange("b2b_gap", done_times[i] - done_times[i-1], 159, 161);
        end

        // Start-bit glitch
        $display("[TB] glitch on idle line");
        driveLine(0, 1'b1, 16);
        d = done16_cnt;
        e = err16_cnt;
        driveLine(0, 1'b0, 4);
        checkOutput("glitch_busy_high", busy16, 1'b1);
        driveLine(0, 1'b1, 8);
        checkOutput("glitch_busy_low", busy16, 1'b0);
        driveLine(0, 1'b1, 16);
        checkOutput("glitch_no_done", done16_cnt, d);
        checkOutput("glitch_no_err", err16_cnt, e);
        applyStimulus(0, 8'h55, 1'b1);
        waitDrain(0);

        // Framing error, line held low, then recovery
        $display("[TB] framing error");
        d = done16_cnt;
        e = err16_cnt;
        applyStimulus(0, 8'hA5, 1'b0);
        driveLine(0, 1'b0, 3 * C16);
        checkOutput("ferr_pulse_count", err16_cnt, e + 1);
        checkOutput("ferr_no_done", done16_cnt, d);
        checkOutput("ferr_data_held", rx_data16, 8'h55);
        checkOutput("ferr_wait_busy", busy16, 1'b1);
        driveLine(0, 1'b1, C16);
        checkOutput("ferr_idle_again", busy16, 1'b0);
        applyStimulus(0, 8'h36, 1'b1);
        waitDrain(0);

        // Reset during DATA bit 4 of 0x7E
        $display("[TB] reset mid-frame");
        b = 8'h7E;
        driveLine(0, 1'b0, C16);
        for (int i = 0; i < 4; i++) driveLine(0, b[i], C16);
        driveLine(0, b[4], C16 / 2);
        checkOutput("midframe_busy", busy16, 1'b1);
        reset = 1'b1;
        rx16  = 1'b1;
        #1;
        checkOutput("inreset_rx_data", rx_data16, 8'h00);
        checkOutput("inreset_rx_done", rx_done16, 1'b0);
        checkOutput("inreset_busy", busy16, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        d = done16_cnt;
        driveLine(0, 1'b1, 2 * C16);
        checkOutput("post_reset_no_done", done16_cnt, d);
        applyStimulus(0, 8'hC3, 1'b1);
        waitDrain(0);
        checkOutput("post_reset_one_done", done16_cnt, d + 1);

        // Odd bit period: 0x00 and 0xFF back to back
        $display("[TB] CLKS_PER_BIT=5");
        driveLine(1, 1'b1, 10);
        applyStimulus(1, 8'h00, 1'b1);
        applyStimulus(1, 8'hFF, 1'b1);
        waitDrain(1);
        checkOutput("c5_done_count", done5_cnt, 2);
        checkOutput("c5_no_err", err5_cnt, 0);
        checkOutput("c5_busy_after", busy5, 1'b0);

        // Global properties
        driveLine(0, 1'b1, 4);
        checkOutput("pulse_violations", pulse_viol, 0);
        checkOutput("total_frame_err16", err16_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
